// File: rtl/mem_arbiter.sv
// Arbitrates one RAM port between an instruction fetch and a data requester.
// Data normally wins, but a waiting fetch is guaranteed a grant after STARVE_MAX data grants.
module mem_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_MAX);
  localparam logic [1:0] RAM_ACCESS = 2'd2;

  typedef enum logic [1:0] {IDLE, IGRANT, DGRANT} state_t;

  state_t        state;
  logic [SW-1:0] streak;
  logic          drec;
  logic          xfer;

  assign drec = dREN | dWEN;
  assign xfer = (ramstate == RAM_ACCESS);

  // BUSY, FREE and ERROR all hold the grant; ERROR is simply retried until ACCESS.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      streak <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (drec && !(iREN && streak == STREAK_MAX))
            state <= DGRANT;
          else if (iREN)
            state <= IGRANT;
        end
        IGRANT: if (!iREN || xfer) state <= IDLE;
        DGRANT: if (!drec || xfer) state <= IDLE;
        default: state <= IDLE;
      endcase

      // Streak only measures how long the current fetch has been starved.
      if (!iREN)
        streak <= '0;
      else if (state == IGRANT && xfer)
        streak <= '0;
      else if (state == DGRANT && drec && xfer && streak != STREAK_MAX)
        streak <= streak + 1'b1;
    end
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (state)
      IGRANT: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
      end
      DGRANT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = !dWEN;
      end
      default: ;
    endcase
  end

  assign iwait = iREN && !(state == IGRANT && xfer);
  assign dwait = drec && !(state == DGRANT && xfer);
  assign iload = ramload;
  assign dload = ramload;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a scoreboard holds every completion the stimulus
// should cause, and each completion the DUT signals is popped and checked against it.
module tb_mem_arbiter;

  localparam logic [1:0] FREE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] ACC  = 2'd2;
  localparam logic [1:0] ERR  = 2'd3;

  typedef struct {
    logic        isdata;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] store;
    logic [31:0] load;
  } sb_entry_t;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN;
  logic [31:0] iload, dload, ramaddr, ramstore;

  sb_entry_t sb[$];
  int nchecks = 0;
  int nfails  = 0;

  mem_arbiter #(.STARVE_MAX(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nchecks++;
    assert (observed === expected) else begin
      nfails++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic expectDone(input logic isdata, input logic wr, input logic [31:0] addr,
                            input logic [31:0] store, input logic [31:0] load);
    sb_entry_t e;
    e.isdata = isdata;
    e.wr     = wr;
    e.addr   = addr;
    e.store  = store;
    e.load   = load;
    sb.push_back(e);
  endtask

  task automatic monitorDone();
    logic      idone, ddone;
    sb_entry_t e;
    idone = iREN && !iwait;
    ddone = (dREN || dWEN) && !dwait;
    if (idone || ddone) begin
      nchecks++;
      assert (sb.size() > 0) else begin
        nfails++;
        $error("[TB] FAIL unexpected_done: observed %0d pending, expected at least 1", sb.size());
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("done_kind",  32'(ddone), 32'(e.isdata));
        checkOutput("done_addr",  ramaddr, e.addr);
        checkOutput("done_wen",   32'(ramWEN), 32'(e.wr));
        checkOutput("done_ren",   32'(ramREN), 32'(!e.wr));
        checkOutput("done_store", ramstore, e.store);
        checkOutput("done_load",  ddone ? dload : iload, e.load);
      end
    end
  endtask

  // One clock cycle: inputs change just after the rising edge, outputs are examined at the falling edge.
  task automatic applyStimulus(input logic ir, input logic [31:0] ia,
                               input logic dr, input logic dw,
                               input logic [31:0] da, input logic [31:0] ds,
                               input logic [1:0] rs, input logic [31:0] rl);
    @(posedge CLK);
    #1;
    iREN = ir; iaddr = ia; dREN = dr; dWEN = dw; daddr = da; dstore = ds;
    ramstate = rs; ramload = rl;
    @(negedge CLK);
    monitorDone();
  endtask

  task automatic pulseReset();
    nRST = 1'b0;
    #1;
    checkOutput("rst_ren",  32'(ramREN), 32'd0);
    checkOutput("rst_wen",  32'(ramWEN), 32'd0);
    checkOutput("rst_addr", ramaddr, 32'd0);
    checkOutput("rst_iwait", 32'(iwait), 32'(iREN));
    checkOutput("rst_dwait", 32'(dwait), 32'(dREN || dWEN));
    nRST = 1'b1;
  endtask

  initial begin
    nRST = 1'b0;
    iREN = 0; dREN = 0; dWEN = 0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;

    // Reset state, including wait outputs reflecting a request held during reset
    #2;
    checkOutput("reset_ren",   32'(ramREN), 32'd0);
    checkOutput("reset_wen",   32'(ramWEN), 32'd0);
    checkOutput("reset_addr",  ramaddr, 32'd0);
    checkOutput("reset_store", ramstore, 32'd0);
    checkOutput("reset_iwait_idle", 32'(iwait), 32'd0);
    iREN = 1'b1; iaddr = 32'h40;
    #1;
    checkOutput("reset_iwait_req", 32'(iwait), 32'd1);
    checkOutput("reset_ren_req",   32'(ramREN), 32'd0);
    iREN = 1'b0;
    #9;
    nRST = 1'b1;

    // Lone instruction fetch, ACCESS two cycles after the grant
    expectDone(1'b0, 1'b0, 32'h40, 32'h0, 32'h2108FFFF);
    applyStimulus(1, 32'h40, 0, 0, 0, 0, FREE, 0);
    checkOutput("if_idle_iwait", 32'(iwait), 32'd1);
    checkOutput("if_idle_ren",   32'(ramREN), 32'd0);
    applyStimulus(1, 32'h40, 0, 0, 0, 0, BUSY, 0);
    checkOutput("if_grant_ren",   32'(ramREN), 32'd1);
    checkOutput("if_grant_wen",   32'(ramWEN), 32'd0);
    checkOutput("if_grant_addr",  ramaddr, 32'h40);
    checkOutput("if_grant_iwait", 32'(iwait), 32'd1);
    applyStimulus(1, 32'h40, 0, 0, 0, 0, BUSY, 0);
    checkOutput("if_busy_ren",   32'(ramREN), 32'd1);
    checkOutput("if_busy_iwait", 32'(iwait), 32'd1);
    applyStimulus(1, 32'h40, 0, 0, 0, 0, ACC, 32'h2108FFFF);
    checkOutput("if_done_iwait", 32'(iwait), 32'd0);
    checkOutput("if_done_iload", iload, 32'h2108FFFF);
    applyStimulus(1, 32'h40, 0, 0, 0, 0, FREE, 0);
    checkOutput("if_after_iwait", 32'(iwait), 32'd1);
    checkOutput("if_after_ren",   32'(ramREN), 32'd0);
    // Regranted, then the fetch is withdrawn: the grant is dropped without completing
    applyStimulus(0, 32'h40, 0, 0, 0, 0, FREE, 0);
    checkOutput("drop_ren_still", 32'(ramREN), 32'd1);
    checkOutput("drop_iwait",     32'(iwait), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, FREE, 0);
    checkOutput("drop_idle_ren", 32'(ramREN), 32'd0);

    // Simultaneous fetch and data write: data first, fetch after one idle cycle
    expectDone(1'b1, 1'b1, 32'h80, 32'hDEAD, 32'h11112222);
    expectDone(1'b0, 1'b0, 32'h44, 32'h0, 32'h11112222);
    applyStimulus(1, 32'h44, 0, 1, 32'h80, 32'hDEAD, FREE, 0);
    checkOutput("both_idle_wen", 32'(ramWEN), 32'd0);
    checkOutput("both_dwait",    32'(dwait), 32'd1);
    applyStimulus(1, 32'h44, 0, 1, 32'h80, 32'hDEAD, ACC, 32'h11112222);
    checkOutput("both_d_store", ramstore, 32'hDEAD);
    checkOutput("both_d_iwait", 32'(iwait), 32'd1);
    applyStimulus(1, 32'h44, 0, 0, 0, 0, ACC, 32'h11112222);
    checkOutput("both_gap_ren", 32'(ramREN), 32'd0);
    checkOutput("both_gap_wen", 32'(ramWEN), 32'd0);
    applyStimulus(1, 32'h44, 0, 0, 0, 0, ACC, 32'h11112222);
    checkOutput("both_i_iwait", 32'(iwait), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, FREE, 0);

    // Starvation limit: four data grants, one fetch, then data wins again
    for (int k = 0; k < 4; k++) expectDone(1'b1, 1'b0, 32'h90, 32'h0, 32'h5555AAAA);
    expectDone(1'b0, 1'b0, 32'h48, 32'h0, 32'h5555AAAA);
    expectDone(1'b1, 1'b0, 32'h90, 32'h0, 32'h5555AAAA);
    for (int k = 0; k < 40 && sb.size() > 0; k++)
      applyStimulus(1, 32'h48, 1, 0, 32'h90, 0, ACC, 32'h5555AAAA);
    checkOutput("starve_drain", 32'(sb.size()), 32'd0);

    // Build the streak back to the limit, then reset during the forced fetch
    for (int k = 0; k < 3; k++) expectDone(1'b1, 1'b0, 32'h90, 32'h0, 32'h5555AAAA);
    for (int k = 0; k < 30 && sb.size() > 0; k++)
      applyStimulus(1, 32'h48, 1, 0, 32'h90, 0, ACC, 32'h5555AAAA);
    checkOutput("streak_drain", 32'(sb.size()), 32'd0);
    applyStimulus(1, 32'h48, 1, 0, 32'h90, 0, BUSY, 0);
    checkOutput("limit_idle_ren", 32'(ramREN), 32'd0);
    applyStimulus(1, 32'h48, 1, 0, 32'h90, 0, BUSY, 0);
    checkOutput("limit_igrant_addr", ramaddr, 32'h48);
    pulseReset();
    applyStimulus(1, 32'h48, 1, 0, 32'h90, 0, BUSY, 0);
    checkOutput("post_rst_data_addr", ramaddr, 32'h90);
    checkOutput("post_rst_data_ren",  32'(ramREN), 32'd1);
    expectDone(1'b1, 1'b0, 32'h90, 32'h0, 32'h12345678);
    applyStimulus(1, 32'h48, 1, 0, 32'h90, 0, ACC, 32'h12345678);
    applyStimulus(0, 0, 0, 0, 0, 0, FREE, 0);

    // Reset during a lone fetch: the fetch is regranted right after release
    applyStimulus(1, 32'h4C, 0, 0, 0, 0, BUSY, 0);
    applyStimulus(1, 32'h4C, 0, 0, 0, 0, BUSY, 0);
    checkOutput("rst_if_ren_before", 32'(ramREN), 32'd1);
    pulseReset();
    applyStimulus(1, 32'h4C, 0, 0, 0, 0, BUSY, 0);
    checkOutput("rst_if_regrant_ren",  32'(ramREN), 32'd1);
    checkOutput("rst_if_regrant_addr", ramaddr, 32'h4C);
    expectDone(1'b0, 1'b0, 32'h4C, 32'h0, 32'h0BADF00D);
    applyStimulus(1, 32'h4C, 0, 0, 0, 0, ACC, 32'h0BADF00D);
    applyStimulus(0, 0, 0, 0, 0, 0, FREE, 0);

    // RAM errors retried: enables held and dwait high until ACCESS
    applyStimulus(0, 0, 1, 0, 32'hA0, 0, FREE, 0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 1, 0, 32'hA0, 0, ERR, 0);
      checkOutput("err_ren",   32'(ramREN), 32'd1);
      checkOutput("err_addr",  ramaddr, 32'hA0);
      checkOutput("err_dwait", 32'(dwait), 32'd1);
    end
    expectDone(1'b1, 1'b0, 32'hA0, 32'h0, 32'hCAFEBABE);
    applyStimulus(0, 0, 1, 0, 32'hA0, 0, ACC, 32'hCAFEBABE);
    checkOutput("err_done_dwait", 32'(dwait), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, FREE, 0);
    checkOutput("err_after_ren", 32'(ramREN), 32'd0);

    // Read and write together: the write takes the port
    expectDone(1'b1, 1'b1, 32'h10, 32'h77, 32'h0);
    applyStimulus(0, 0, 1, 1, 32'h10, 32'h77, FREE, 0);
    applyStimulus(0, 0, 1, 1, 32'h10, 32'h77, ACC, 32'h0);
    checkOutput("rw_wen", 32'(ramWEN), 32'd1);
    checkOutput("rw_ren", 32'(ramREN), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, FREE, 0);

    checkOutput("final_pending", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4: max consecutive data grants while an instruction request waits.
REQ-002 CLK  in  1  system clock; all state updates on rising edge.
REQ-003 nRST  in  1  reset, asynchronous, active-low.
REQ-004 iREN  in  1  instruction read request.
REQ-005 iaddr  in  32  instruction word address.
REQ-006 iwait  out  1  instruction request not yet satisfied.
REQ-007 iload  out  32  instruction read data.
REQ-008 dREN  in  1  data read request.
REQ-009 dWEN  in  1  data write request.
REQ-010 daddr  in  32  data word address.
REQ-011 dstore  in  32  data write value.
REQ-012 dwait  out  1  data request not yet satisfied.
REQ-013 dload  out  32  data read value.
REQ-014 ramREN  out  1  RAM read enable.
REQ-015 ramWEN  out  1  RAM write enable.
REQ-016 ramaddr  out  32  RAM address.
REQ-017 ramstore  out  32  RAM write data.
REQ-018 ramload  in  32  RAM read data.
REQ-019 ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS (transfer done this cycle), 3 ERROR.

Function
REQ-020 FSM states SHALL be IDLE, IGRANT, DGRANT; single RAM port owned by at most one requester.
REQ-021 IDLE: drec = dREN|dWEN; if drec and not (iREN and streak==STARVE_MAX) -> DGRANT; else if iREN -> IGRANT; else stay IDLE.
REQ-022 IGRANT: ramREN=1, ramWEN=0, ramaddr=iaddr, ramstore=0.
REQ-023 DGRANT: ramaddr=daddr, ramstore=dstore; dWEN=1 -> ramWEN=1, ramREN=0 (write wins if dREN and dWEN both high); else ramREN=1, ramWEN=0.
REQ-024 IDLE: ramREN=ramWEN=0, ramaddr=0, ramstore=0.
REQ-025 Grant completes in the cycle ramstate==ACCESS; next state IDLE.
REQ-026 iwait = iREN and not (state==IGRANT and ramstate==ACCESS), combinational; dwait likewise with drec and DGRANT.
REQ-027 iload = dload = ramload (pass-through); valid only in a completing cycle.
REQ-028 Latency: request seen in IDLE at cycle N -> RAM enables at N+1 -> earliest wait low at N+1; completion returns to IDLE at next edge, so back-to-back grants are separated by one IDLE cycle.
REQ-029 ramstate BUSY/FREE in a grant state: hold state and RAM outputs.
REQ-030 ramstate ERROR in a grant state: hold state and keep enables asserted (retry); wait stays high.
REQ-031 Requester drops its enable(s) while granted: next state IDLE; no completion counted.
REQ-032 Counter streak (width clog2(STARVE_MAX+1)): +1 on each completed data grant while iREN=1, saturating at STARVE_MAX; cleared to 0 on completed instruction grant or any cycle with iREN=0.
REQ-033 Requesters hold address/data stable while wait is high; the arbiter does not latch them.

Reset
REQ-034 nRST low SHALL immediately force state IDLE, streak 0, ramREN=ramWEN=0, ramaddr=ramstore=0, independent of CLK.
REQ-035 Reset asserted mid-grant SHALL abandon the transfer; wait outputs follow REQ-026 with state IDLE (high if request present).
REQ-036 First grant after reset release SHALL follow REQ-021 from IDLE.

Verification
REQ-037 Only iREN=1, iaddr=0x40, ramstate ACCESS 2 cycles after grant, ramload=0x2108FFFF -> ramREN=1, ramaddr=0x40; iwait low exactly one cycle with iload=0x2108FFFF.
REQ-038 iREN=1 and dWEN=1 same cycle, daddr=0x80, dstore=0xDEAD -> DGRANT first, ramWEN=1, ramstore=0xDEAD; IGRANT after one IDLE cycle.
REQ-039 iREN held, dREN continuously reasserted, ACCESS every grant -> exactly 4 data grants, then one instruction grant, then streak 0.
REQ-040 DGRANT with ramstate ERROR for 3 cycles then ACCESS -> enables held throughout, dwait high until ACCESS cycle, single completion.
REQ-041 nRST pulsed low during IGRANT with ramstate BUSY -> enables drop asynchronously, state IDLE, streak 0; iREN still high regrants next cycle after release.
REQ-042 dREN=dWEN=1, daddr=0x10 -> ramWEN=1, ramREN=0.
